// File: rtl/lat_chk_pkg.sv
// Shared definitions for the in-order latency checker: timestamp width and
// the expected-value rule applied to every accepted input.
package lat_chk_pkg;

  // Timestamp wide enough that the oldest legal head age (MAX_LAT+1) never aliases.
  function automatic int tsw_width(input int max_lat);
    return $clog2(max_lat + 2) + 1;
  endfunction

  function automatic logic [31:0] exp_value(input logic [31:0] data, input int mode,
                                            input logic [31:0] thresh);
    if (mode == 1 && data >= thresh) return data + 32'd1;
    return data;
  endfunction

endpackage

// File: rtl/lat_chk_fifo.sv
// Synchronous FIFO holding outstanding transfers; head and count are exposed
// so the checker can age and compare the oldest entry.
module lat_chk_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  entry_t                 wdata_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     rdPtr_q, wrPtr_q;
  logic [AW:0]       count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop_i)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/inorder_latency_checker.sv
// Checks that every accepted input reappears at the output in order, with the
// expected value, inside the [MIN_LAT:MAX_LAT] latency window.
module inorder_latency_checker
  import lat_chk_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int MIN_LAT  = 1,
  parameter int MAX_LAT  = 5,
  parameter int EXP_MODE = 0,
  parameter int THRESH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  input  logic [WIDTH-1:0]       portin,
  input  logic                   out_en,
  input  logic [WIDTH-1:0]       portout,
  output logic                   pass,
  output logic                   err_mismatch,
  output logic                   err_early,
  output logic                   err_late,
  output logic                   err_spurious,
  output logic                   err_overflow,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            pass_count,
  output logic [15:0]            err_count
);

  localparam int TSW = tsw_width(MAX_LAT);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam logic [TSW-1:0] MIN_AGE = TSW'(MIN_LAT);
  localparam logic [TSW-1:0] MAX_AGE = TSW'(MAX_LAT);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inorder_latency_checker: DEPTH must be a power of two >= 2");
  end
  if (MIN_LAT < 0 || MAX_LAT < MIN_LAT) begin : g_bad_window
    $error("inorder_latency_checker: require 0 <= MIN_LAT <= MAX_LAT");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("inorder_latency_checker: WIDTH must be 1..32");
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TSW-1:0]   ts;
  } entry_t;

  entry_t          head, wrEntry;
  logic            fifoEmpty, fifoFull;
  logic [CW-1:0]   fifoCount;
  logic [TSW-1:0]  now_q, age;
  logic            push, pop;
  logic            pass_d, mism_d, early_d, late_d, spur_d, ovf_d;
  logic            pass_q, mism_q, early_q, late_q, spur_q, ovf_q;
  logic [15:0]     passCount_q, errCount_q;

  assign wrEntry.data = WIDTH'(exp_value(32'(portin), EXP_MODE, 32'(THRESH)));
  assign wrEntry.ts   = now_q;
  assign age          = now_q - head.ts;

  lat_chk_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wrEntry),
    .head_o  (head),
    .count_o (fifoCount),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull)
  );

  // The head is judged before this cycle's push, so a same-cycle input is never matched.
  always_comb begin
    pop     = 1'b0;
    push    = 1'b0;
    pass_d  = 1'b0;
    mism_d  = 1'b0;
    early_d = 1'b0;
    late_d  = 1'b0;
    spur_d  = 1'b0;
    ovf_d   = 1'b0;
    if (!fifoEmpty) begin
      if (out_en) begin
        pop     = 1'b1;
        mism_d  = (head.data != portout);
        early_d = (age < MIN_AGE);
        pass_d  = !mism_d && !early_d;
      end else if (age > MAX_AGE) begin
        pop    = 1'b1;
        late_d = 1'b1;
      end
    end else if (out_en) begin
      spur_d = 1'b1;
    end
    if (in_en) begin
      if (fifoFull && !pop) ovf_d = 1'b1;
      else                  push  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_q       <= '0;
      pass_q      <= 1'b0;
      mism_q      <= 1'b0;
      early_q     <= 1'b0;
      late_q      <= 1'b0;
      spur_q      <= 1'b0;
      ovf_q       <= 1'b0;
      passCount_q <= '0;
      errCount_q  <= '0;
    end else begin
      now_q   <= now_q + TSW'(1);
      pass_q  <= pass_d;
      mism_q  <= mism_d;
      early_q <= early_d;
      late_q  <= late_d;
      spur_q  <= spur_d;
      ovf_q   <= ovf_d;
      if (pass_d && passCount_q != 16'hFFFF) passCount_q <= passCount_q + 16'd1;
      if ((mism_d | early_d | late_d | spur_d | ovf_d) && errCount_q != 16'hFFFF)
        errCount_q <= errCount_q + 16'd1;
    end
  end

  assign pass         = pass_q;
  assign err_mismatch = mism_q;
  assign err_early    = early_q;
  assign err_late     = late_q;
  assign err_spurious = spur_q;
  assign err_overflow = ovf_q;
  assign occupancy    = fifoCount;
  assign pass_count   = passCount_q;
  assign err_count    = errCount_q;

endmodule

// File: tb/tb_inorder_latency_checker.sv
// Directed bench for inorder_latency_checker (transform mode, DEPTH 4, window 2..5)
// with a scoreboard of pushed expected values and push cycles.
module tb_inorder_latency_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       inEn, outEn;
  logic [7:0] portIn, portOut;
  logic       pass, errMismatch, errEarly, errLate, errSpurious, errOverflow;
  logic [2:0] occupancy;
  logic [15:0] passCount, errCount;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } sb_t;

  sb_t sbQ[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  expPass = 0;
  int  expErr = 0;

  inorder_latency_checker #(
    .WIDTH(8), .DEPTH(4), .MIN_LAT(2), .MAX_LAT(5), .EXP_MODE(1), .THRESH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_en        (inEn),
    .portin       (portIn),
    .out_en       (outEn),
    .portout      (portOut),
    .pass         (pass),
    .err_mismatch (errMismatch),
    .err_early    (errEarly),
    .err_late     (errLate),
    .err_spurious (errSpurious),
    .err_overflow (errOverflow),
    .occupancy    (occupancy),
    .pass_count   (passCount),
    .err_count    (errCount)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] expVal(input logic [7:0] v);
    return (v >= 8'd4) ? v + 8'd1 : v;
  endfunction

  // Pulse vector order: {pass, mismatch, early, late, spurious, overflow}.
  task automatic checkOutput(input string tag, input logic [5:0] expPulses);
    logic [5:0] obs;
    obs = {pass, errMismatch, errEarly, errLate, errSpurious, errOverflow};
    checks++;
    assert (obs === expPulses) else begin
      failures++;
      $error("[TB] FAIL %s pulses observed=%b expected=%b", tag, obs, expPulses);
    end
    checks++;
    assert (occupancy === 3'(sbQ.size())) else begin
      failures++;
      $error("[TB] FAIL %s occupancy observed=%0d expected=%0d", tag, occupancy, sbQ.size());
    end
    checks++;
    assert (passCount === 16'(expPass)) else begin
      failures++;
      $error("[TB] FAIL %s pass_count observed=%0d expected=%0d", tag, passCount, expPass);
    end
    checks++;
    assert (errCount === 16'(expErr)) else begin
      failures++;
      $error("[TB] FAIL %s err_count observed=%0d expected=%0d", tag, errCount, expErr);
    end
  endtask

  task automatic checkCounts(input string tag, input int occExp, input int passExp,
                             input int errExp);
    checks++;
    assert (occupancy === 3'(occExp)) else begin
      failures++;
      $error("[TB] FAIL %s occupancy observed=%0d expected=%0d", tag, occupancy, occExp);
    end
    checks++;
    assert (passCount === 16'(passExp)) else begin
      failures++;
      $error("[TB] FAIL %s pass_count observed=%0d expected=%0d", tag, passCount, passExp);
    end
    checks++;
    assert (errCount === 16'(errExp)) else begin
      failures++;
      $error("[TB] FAIL %s err_count observed=%0d expected=%0d", tag, errCount, errExp);
    end
  endtask

  task automatic checkReset(input string tag);
    logic [5:0] obs;
    obs = {pass, errMismatch, errEarly, errLate, errSpurious, errOverflow};
    checks++;
    assert (obs === 6'b0) else begin
      failures++;
      $error("[TB] FAIL %s pulses observed=%b expected=000000", tag, obs);
    end
    checkCounts(tag, 0, 0, 0);
  endtask

  // One clock of stimulus: the scoreboard predicts the pulses for this edge.
  task automatic applyStimulus(input logic ie, input logic [7:0] pi,
                               input logic oe, input logic [7:0] po);
    logic [5:0] expP;
    sb_t        ent;
    int         age;
    expP = '0;
    inEn = ie; portIn = pi; outEn = oe; portOut = po;
    if (sbQ.size() > 0) begin
      age = cyc - sbQ[0].cyc;
      if (oe) begin
        expP[4] = (sbQ[0].val != po);
        expP[3] = (age < 2);
        expP[5] = !(expP[4] | expP[3]);
        void'(sbQ.pop_front());
      end else if (age > 5) begin
        expP[2] = 1'b1;
        void'(sbQ.pop_front());
      end
    end else if (oe) begin
      expP[1] = 1'b1;
    end
    if (ie) begin
      if (sbQ.size() == 4) expP[0] = 1'b1;
      else begin
        ent.val = expVal(pi);
        ent.cyc = cyc;
        sbQ.push_back(ent);
      end
    end
    if (expP[5]) expPass++;
    if (|expP[4:0]) expErr++;
    @(posedge clk);
    cyc++;
    #1;
    checkOutput($sformatf("step%0d", cyc), expP);
  endtask

  initial begin
    rst = 1'b1; inEn = 1'b0; outEn = 1'b0; portIn = '0; portOut = '0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset_state");
    rst = 1'b0;

    for (int s = 0; s < 18; s++)
      applyStimulus(s % 2 == 0 && s < 16, 8'(s / 2),
                    s >= 2 && s % 2 == 0, expVal(8'((s - 2) / 2)));
    checkCounts("xform_pass", 0, 8, 0);

    for (int s = 0; s < 18; s++)
      applyStimulus(s % 2 == 0 && s < 16, 8'(s / 2),
                    s >= 2 && s % 2 == 0, 8'((s - 2) / 2));
    checkCounts("identity_dut_mismatch", 0, 12, 4);

    applyStimulus(1'b1, 8'd1, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd1);
    checkCounts("early", 0, 12, 5);

    applyStimulus(1'b1, 8'd2, 1'b0, 8'd0);
    repeat (6) applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    checkCounts("late", 0, 12, 6);

    applyStimulus(1'b1, 8'd3, 1'b1, 8'h55);
    checkCounts("spurious", 1, 12, 7);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd3);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'd0);
    checkCounts("overflow", 4, 13, 8);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b1, 8'(i));

    for (int i = 4; i < 8; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd8, 1'b1, 8'd5);
    checkCounts("full_push_with_pop", 4, 18, 8);
    for (int i = 6; i < 10; i++) applyStimulus(1'b0, 8'd0, 1'b1, 8'(i));
    checkCounts("drain", 0, 22, 8);

    for (int i = 1; i < 4; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'd0);
    inEn = 1'b0;
    #2 rst = 1'b1;
    #1 checkReset("rst_assert");
    sbQ.delete();
    expPass = 0;
    expErr = 0;
    @(posedge clk);
    #1;
    checkReset("rst_held");
    rst = 1'b0;
    cyc = 0;

    applyStimulus(1'b1, 8'd5, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd6);
    checkCounts("post_reset", 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
